// File: rtl/dekatron_pkg.sv
// Shared definitions for the dekatron digit loader: state encoding, digit
// count, step direction and the mod-10 distance helper.
package dekatron_pkg;

  localparam int unsigned DIGITS = 10;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PH_A = 3'd1;
  localparam logic [2:0] ST_PH_B = 3'd2;
  localparam logic [2:0] ST_GAP  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef enum logic {
    DIR_FWD = 1'b0,
    DIR_BWD = 1'b1
  } dir_e;

  // (tgt - cur) mod 10 for BCD digits 0..9
  function automatic logic [3:0] mod10_diff(input logic [3:0] tgt, input logic [3:0] cur);
    logic [4:0] s;
    s = 5'(tgt) + 5'(DIGITS) - 5'(cur);
    if (s >= 5'(DIGITS)) s = s - 5'(DIGITS);
    return s[3:0];
  endfunction

endpackage

// File: rtl/dekatron_phase_timer.sv
// Loadable down-counter timing the guide phases and the inter-step gap.
//   clk, rst_n : clock, async active-low reset
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : phase length minus one
//   tc_c       : counter at zero, i.e. current cycle is the last of the phase
module dekatron_phase_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc_c
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: load, else count down and park at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load)               cnt_d = load_val;
    else if (cnt_q != '0)   cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc_c = (cnt_q == '0);

endmodule

// File: rtl/onehot_to_8421.sv
// One-hot (10 positions) to 8-4-2-1 BCD encoder.
//   onehot : one-hot digit position, bit i = digit i
//   bcd_c  : combinational BCD value of the set position
module onehot_to_8421
  import dekatron_pkg::*;
(
  input  logic [DIGITS-1:0] onehot,
  output logic [3:0]        bcd_c
);

  // OR together the index of every set bit; with a one-hot input this is the index
  always_comb begin
    bcd_c = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (onehot[i]) bcd_c = bcd_c | 4'(i);
    end
  end

endmodule

// File: rtl/dekatron_digit_loader.sv
// Steps a dekatron counting tube from its current cathode to a requested BCD
// digit by emitting guide-pulse pairs, taking the shorter way round.
//   Clk, Rst_n     : clock, async active-low reset
//   Load, Digit    : load request and target digit (sampled when Ready=1)
//   Ready          : idle, a load is accepted this cycle
//   Done, Err      : one-cycle pulses: target reached / invalid digit
//   Guide1, Guide2 : guide electrode drives
//   Pos, Bcd       : current cathode, one-hot and BCD
module dekatron_digit_loader
  import dekatron_pkg::*;
#(
  parameter int unsigned PULSE_LEN = 4,
  parameter int unsigned GAP_LEN   = 2
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Load,
  input  logic [3:0]        Digit,
  output logic              Ready,
  output logic              Done,
  output logic              Err,
  output logic              Guide1,
  output logic              Guide2,
  output logic [DIGITS-1:0] Pos,
  output logic [3:0]        Bcd
);

  localparam int unsigned MAX_LEN = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_LEN - 1);

  logic [2:0]        state_q, state_d;
  dir_e              dir_q, dir_d;
  logic [2:0]        steps_q, steps_d;
  logic [DIGITS-1:0] pos_q, pos_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              guide1_q, guide1_d;
  logic              guide2_q, guide2_d;

  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;
  logic              tmr_tc_c;
  logic [3:0]        bcd_c;
  logic [3:0]        diff;

  dekatron_phase_timer #(.W(CNT_W)) u_timer (
    .clk      (Clk),
    .rst_n    (Rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc_c     (tmr_tc_c)
  );

  onehot_to_8421 u_enc (
    .onehot (pos_q),
    .bcd_c  (bcd_c)
  );

  assign diff = mod10_diff(Digit, bcd_c);

  // Next state, step bookkeeping and registered-output next values
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    steps_d  = steps_q;
    pos_d    = pos_q;
    err_d    = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = PULSE_LOAD;

    case (state_q)
      ST_IDLE: begin
        if (Load) begin
          if (Digit > 4'd9) begin
            err_d = 1'b1;
          end else if (diff == 4'd0) begin
            state_d = ST_DONE;
          end else begin
            // A distance of exactly 5 goes forward
            dir_d    = (diff <= 4'd5) ? DIR_FWD : DIR_BWD;
            steps_d  = (diff <= 4'd5) ? 3'(diff) : 3'(4'(DIGITS) - diff);
            state_d  = ST_PH_A;
            tmr_load = 1'b1;
          end
        end
      end
      ST_PH_A: begin
        if (tmr_tc_c) begin
          state_d  = ST_PH_B;
          tmr_load = 1'b1;
        end
      end
      ST_PH_B: begin
        // Tube moves one cathode as the second guide pulse ends
        if (tmr_tc_c) begin
          pos_d    = (dir_q == DIR_FWD) ? {pos_q[DIGITS-2:0], pos_q[DIGITS-1]}
                                        : {pos_q[0], pos_q[DIGITS-1:1]};
          steps_d  = steps_q - 3'd1;
          state_d  = ST_GAP;
          tmr_load = 1'b1;
          tmr_val  = GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (tmr_tc_c) begin
          if (steps_q != 3'd0) begin
            state_d  = ST_PH_A;
            tmr_load = 1'b1;
          end else begin
            state_d  = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs follow the state being entered so they line up with it
    ready_d  = (state_d == ST_IDLE);
    done_d   = (state_d == ST_DONE);
    guide1_d = ((state_d == ST_PH_A) && (dir_d == DIR_FWD)) ||
               ((state_d == ST_PH_B) && (dir_d == DIR_BWD));
    guide2_d = ((state_d == ST_PH_A) && (dir_d == DIR_BWD)) ||
               ((state_d == ST_PH_B) && (dir_d == DIR_FWD));
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= ST_IDLE;
      dir_q    <= DIR_FWD;
      steps_q  <= 3'd0;
      pos_q    <= DIGITS'(1);
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      guide1_q <= 1'b0;
      guide2_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      steps_q  <= steps_d;
      pos_q    <= pos_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      err_q    <= err_d;
      guide1_q <= guide1_d;
      guide2_q <= guide2_d;
    end
  end

  assign Ready  = ready_q;
  assign Done   = done_q;
  assign Err    = err_q;
  assign Guide1 = guide1_q;
  assign Guide2 = guide2_q;
  assign Pos    = pos_q;
  assign Bcd    = bcd_c;

endmodule

// File: tb/tb_dekatron_digit_loader.sv
// Scoreboard bench for dekatron_digit_loader: each accepted load pushes the
// expected per-cycle outputs and Done timing; a monitor pops and compares.
module tb_dekatron_digit_loader;

  localparam int PULSE_LEN = 4;
  localparam int GAP_LEN   = 2;

  logic       Clk   = 1'b0;
  logic       Rst_n = 1'b1;
  logic       Load  = 1'b0;
  logic [3:0] Digit = 4'd0;
  logic       Ready, Done, Err, Guide1, Guide2;
  logic [9:0] Pos;
  logic [3:0] Bcd;

  dekatron_digit_loader #(.PULSE_LEN(PULSE_LEN), .GAP_LEN(GAP_LEN)) dut (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .Load   (Load),
    .Digit  (Digit),
    .Ready  (Ready),
    .Done   (Done),
    .Err    (Err),
    .Guide1 (Guide1),
    .Guide2 (Guide2),
    .Pos    (Pos),
    .Bcd    (Bcd)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       g1;
    logic       g2;
    logic       rdy;
    logic       done;
    logic       err;
    logic [3:0] dig;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];
  int   cyc       = 0;
  int   n_chk     = 0;
  int   n_fail    = 0;
  int   model_dig = 0;
  bit   mon_en    = 1'b0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic g1, input logic g2, input logic rdy,
                              input logic done, input logic err, input int dig);
    exp_t e;
    e.g1 = g1; e.g2 = g2; e.rdy = rdy; e.done = done; e.err = err; e.dig = 4'(dig);
    return e;
  endfunction

  function automatic int onehot(input int d);
    return 1 << d;
  endfunction

  // Expected behaviour of a load accepted at the coming clock edge
  task automatic push_load(input int d);
    int c, diff, steps, p;
    bit fwd;
    c = model_dig;
    if (d > 9) begin
      exp_q.push_back(mk(0, 0, 1, 0, 1, c));
      return;
    end
    diff = (d - c + 10) % 10;
    if (diff == 0) begin
      exp_q.push_back(mk(0, 0, 0, 1, 0, c));
      done_q.push_back(cyc + 1);
      return;
    end
    fwd   = (diff <= 5);
    steps = fwd ? diff : 10 - diff;
    p     = c;
    for (int s = 0; s < steps; s++) begin
      for (int k = 0; k < PULSE_LEN; k++) exp_q.push_back(mk(fwd, !fwd, 0, 0, 0, p));
      for (int k = 0; k < PULSE_LEN; k++) exp_q.push_back(mk(!fwd, fwd, 0, 0, 0, p));
      p = fwd ? (p + 1) % 10 : (p + 9) % 10;
      for (int k = 0; k < GAP_LEN; k++) exp_q.push_back(mk(0, 0, 0, 0, 0, p));
    end
    exp_q.push_back(mk(0, 0, 0, 1, 0, p));
    done_q.push_back(cyc + steps * (2 * PULSE_LEN + GAP_LEN) + 1);
    model_dig = d;
  endtask

  // Per-cycle output check against the scoreboard (idle when it is empty)
  always @(posedge Clk) begin
    exp_t e;
    cyc++;
    #1;
    if (mon_en) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else                  e = mk(0, 0, 1, 0, 0, model_dig);
      check_eq("guide1", int'(Guide1), int'(e.g1));
      check_eq("guide2", int'(Guide2), int'(e.g2));
      check_eq("guide_overlap", int'(Guide1 & Guide2), 0);
      check_eq("ready", int'(Ready), int'(e.rdy));
      check_eq("done", int'(Done), int'(e.done));
      check_eq("err", int'(Err), int'(e.err));
      check_eq("pos", int'(Pos), onehot(int'(e.dig)));
      check_eq("bcd", int'(Bcd), int'(e.dig));
      if (Done) begin
        if (done_q.size() > 0) check_eq("done_latency", cyc, done_q.pop_front());
        else                   check_eq("done_unexpected", int'(Done), 0);
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_ready"}, int'(Ready), 1);
    check_eq({tag, "_pos"}, int'(Pos), 1);
    check_eq({tag, "_bcd"}, int'(Bcd), 0);
    check_eq({tag, "_guide1"}, int'(Guide1), 0);
    check_eq({tag, "_guide2"}, int'(Guide2), 0);
    check_eq({tag, "_done"}, int'(Done), 0);
    check_eq({tag, "_err"}, int'(Err), 0);
  endtask

  task automatic load_digit(input int d);
    int n;
    n = 0;
    @(negedge Clk);
    while (!Ready && n < 300) begin
      @(negedge Clk);
      n++;
    end
    check_eq("ready_wait", int'(Ready), 1);
    Load  = 1'b1;
    Digit = 4'(d);
    push_load(d);
    @(negedge Clk);
    Load  = 1'b0;
    Digit = 4'($urandom_range(0, 15));
  endtask

  // Load pulse while busy: must leave the expectations untouched
  task automatic poke_busy(input int d);
    @(negedge Clk);
    check_eq("busy_ready", int'(Ready), 0);
    Load  = 1'b1;
    Digit = 4'(d);
    @(negedge Clk);
    Load  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      @(negedge Clk);
      n++;
    end
    check_eq("wait_idle", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Asynchronous reset before any clock edge
    #2 Rst_n = 1'b0;
    #1 check_reset_vals("reset");
    mon_en = 1'b1;
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;

    // Forward 0 -> 3
    load_digit(3);
    wait_idle();
    // Tie: 3 -> 8 is five steps forward
    load_digit(8);
    wait_idle();
    // Forward across the wrap: 8 -> 1
    load_digit(1);
    wait_idle();
    // Backward 1 -> 9 through 0
    load_digit(9);
    wait_idle();
    // Invalid digit
    load_digit(12);
    wait_idle();
    // Already there
    load_digit(9);
    wait_idle();
    // 9 -> 4 forward, with a load attempt while busy
    load_digit(4);
    poke_busy(7);
    wait_idle();

    // Reset during PH_B of the second step of 4 -> 7
    load_digit(7);
    repeat (15) @(posedge Clk);
    #3;
    check_eq("pre_reset_guide2", int'(Guide2), 1);
    Rst_n = 1'b0;
    #1 check_reset_vals("mid_reset");
    exp_q.delete();
    done_q.delete();
    model_dig = 0;
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    load_digit(2);
    wait_idle();

    // Assorted loads including invalid digits
    for (int i = 0; i < 8; i++) begin
      load_digit(int'($urandom_range(0, 15)));
      wait_idle();
    end
    repeat (3) @(negedge Clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dekatron_digit_loader.md
Name: dekatron_digit_loader

Overview:
- Sequential BCD-to-tube driver for a dekatron digit. It steps the tube from its current cathode to a requested 8-4-2-1 digit by generating guide-pulse pairs.
- Keeps a one-hot model of the cathode position and reports it both as one-hot and as BCD.
- Sits between the digit/register control logic, which issues load requests, and the guide-electrode drivers of one counting tube.

Parameters:
- PULSE_LEN, 4, cycles each guide output is held high per phase (1..255).
- GAP_LEN, 2, cycles with both guides low after each step (1..255).

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- Load  in  1  request to move the tube to Digit; sampled only when Ready=1.
- Digit  in  4  target digit, 8-4-2-1 BCD.
- Ready  out  1  idle; a load is accepted this cycle.
- Done  out  1  one-cycle pulse when the target is reached.
- Err  out  1  one-cycle pulse when Load carried an invalid Digit (10..15).
- Guide1  out  1  first guide electrode drive.
- Guide2  out  1  second guide electrode drive.
- Pos  out  10  one-hot current cathode position.
- Bcd  out  4  current position, 8-4-2-1.

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- Reset values: state IDLE, Pos=10'b0000000001, Bcd=0, Ready=1, Done=0, Err=0, Guide1=0, Guide2=0.
- Pos is exactly one-hot at all times. Bcd is combinationally encoded from Pos.
- FSM states: IDLE, PH_A, PH_B, GAP, DONE.
- IDLE:
  - Ready=1.
  - Load=1 with Digit>9: Err=1 next cycle, state stays IDLE, Pos unchanged.
  - Load=1 with valid Digit: compute diff = (Digit - Bcd) mod 10.
  - diff=0: go to DONE.
  - diff 1..5: direction forward, steps=diff.
  - diff 6..9: direction backward, steps=10-diff. A tie at 5 goes forward.
  - With steps>0, latch target, direction and step count, then go to PH_A.
- PH_A: lasts PULSE_LEN cycles. Forward drives Guide1=1; backward drives Guide2=1.
- PH_B: lasts PULSE_LEN cycles and drives the other guide.
- On the clock edge leaving PH_B:
  - Forward rotates Pos one place up, 9 wraps to 0.
  - Backward rotates Pos one place down, 0 wraps to 9.
  - The step count is decremented.
- GAP: lasts GAP_LEN cycles with both guides low. On exit, go to PH_A if steps remain, otherwise go to DONE.
- DONE: lasts one cycle with Done=1, then returns to IDLE.
- Guides are never high together. Both are low in IDLE, GAP and DONE.
- Latency from the accepting edge to the Done cycle is steps*(2*PULSE_LEN+GAP_LEN)+1 cycles. With defaults that is 10 cycles per step plus 1.
- Load while Ready=0 is ignored, with no queueing. Digit is sampled only at acceptance.
- Reset mid-operation immediately drops both guides, returns to IDLE and sets Pos to 0. The tube's own reset line returns the tube to cathode 0 in step with this.
- The phase counter is wide enough for max(PULSE_LEN, GAP_LEN). The step counter is 3 bits (max 5).

Decomposition:
- Shared dekatron package holds:
  - FSM state encoding.
  - The DIGITS=10 constant.
  - The direction enum (FWD, BWD).
  - A mod-10 difference function.
- Bcd is produced by instantiating the codebase's existing one-hot-to-8421 encoder on Pos.
- One natural sub-module, dekatron_phase_timer: a loadable down-counter with a terminal-count flag, used for PH_A, PH_B and GAP durations.

Test Plan:
- Reset: assert Rst_n=0 asynchronously mid-cycle -> Pos=0x001, Bcd=0, guides 0, Ready=1 without waiting for a clock edge.
- Forward: from 0, Load Digit=3 -> Guide1 high 4 cycles then Guide2 high 4 cycles, three times. Pos passes 0x002, 0x004, 0x008. Done pulses 31 cycles after acceptance. Bcd=3.
- Tie and wrap: from 3, Load 8 -> forward 5 steps, Done at 51 cycles. Then Load 1 -> diff 3, forward through 9, 0, 1. Bcd=1.
- Backward: from 1, Load 9 -> diff 8, so 2 backward steps with Guide2 leading Guide1. Pos passes 0x001 then 0x200. Done at 21 cycles.
- Invalid and zero: Load Digit=12 -> Err pulse, no guide activity, Pos unchanged. Load Digit equal to the current position -> Done next cycle, no pulses. Load while busy is ignored.
- Reset mid-step: assert Rst_n=0 during PH_B of the 2nd step -> guides 0 immediately, Pos=0x001, Ready=1. A fresh Load 2 then completes normally in 21 cycles.
